// File: rtl/inst_queue_pkg.sv
// Shared constants for the instruction queue between fetch and dual-issue decode.
package inst_queue_pkg;

    localparam int BPB_PACKET_WIDTH = 35;
    localparam int INST_QUEUE_DEPTH = 16;

    localparam logic RST_ENABLE        = 1'b1;
    localparam logic IN_DELAY_SLOT     = 1'b1;
    localparam logic NOT_IN_DELAY_SLOT = 1'b0;

    typedef enum logic {
        SINGLE_ISSUE = 1'b0,
        DUAL_ISSUE   = 1'b1
    } issue_mode_e;

endpackage

// File: rtl/iq_ram.sv
// Entry storage for the instruction queue: two write ports, two asynchronous read ports.
module iq_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INST_QUEUE_DEPTH,
    parameter int PTR_W  = 4,
    parameter int DATA_W = 64 + BPB_PACKET_WIDTH,
    parameter int RD2_W  = 64
) (
    input  logic              clk,
    input  logic              we1,
    input  logic [PTR_W-1:0]  waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we2,
    input  logic [PTR_W-1:0]  waddr2,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [PTR_W-1:0]  raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [PTR_W-1:0]  raddr2,
    output logic [RD2_W-1:0]  rdata2
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  sel1;
    logic [DEPTH-1:0]  sel2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign sel1[gi] = we1 && (waddr1 == PTR_W'(gi));
            assign sel2[gi] = we2 && (waddr2 == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (sel2[i]) begin
                mem[i] <= wdata2;
            end else if (sel1[i]) begin
                mem[i] <= wdata1;
            end
        end
    end

    // Port 2 only feeds the head+1 address/instruction, so the packet is not read out.
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2][DATA_W-1 -: RD2_W];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue: accepts up to two fetched instructions per cycle and
// presents the two oldest to decode, popping one or two per issue decision.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH,
    parameter int PTR_W = 4,
    parameter int PKT_W = BPB_PACKET_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fetch_valid1,
    input  logic             fetch_valid2,
    input  logic [31:0]      fetch_addr1,
    input  logic [31:0]      fetch_addr2,
    input  logic [31:0]      fetch_inst1,
    input  logic [31:0]      fetch_inst2,
    input  logic [PKT_W-1:0] fetch_pkt1,
    input  logic [PKT_W-1:0] fetch_pkt2,
    output logic             queue_full,
    input  logic             issue_i,
    input  logic             issue_mode_i,
    input  logic             next_inst_in_delayslot_i,
    output logic             issue_en1,
    output logic [31:0]      inst_addr_o1,
    output logic [31:0]      inst_addr_o2,
    output logic [31:0]      inst_o1,
    output logic [31:0]      inst_o2,
    output logic [PKT_W-1:0] predict_pkt_o,
    output logic             is_in_delayslot_o
);

    localparam int ENTRY_W = 64 + PKT_W;

    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [PTR_W:0]     count_reg;
    logic               delayslot_reg;

    logic [PTR_W-1:0]   head_next;
    logic [PTR_W-1:0]   tail_next;
    logic [PTR_W:0]     count_next;
    logic [1:0]         push_n;
    logic [1:0]         pop_n;
    logic               clear;

    logic [ENTRY_W-1:0] rd_head;
    logic [63:0]        rd_second;

    assign clear = (rst == RST_ENABLE) || flush;

    // Full leaves room for a two-wide fetch; a same-cycle pop is not credited.
    assign queue_full = (count_reg >= (PTR_W+1)'(DEPTH - 1));

    always_comb begin
        push_n = 2'd0;
        if (!queue_full && fetch_valid1) begin
            push_n = fetch_valid2 ? 2'd2 : 2'd1;
        end
    end

    // A dual issue against a lone entry only consumes that entry; the NOP slot is synthetic.
    always_comb begin
        pop_n = 2'd0;
        if (issue_i && (count_reg != '0)) begin
            if ((issue_mode_i == DUAL_ISSUE) && (count_reg >= (PTR_W+1)'(2))) begin
                pop_n = 2'd2;
            end else begin
                pop_n = 2'd1;
            end
        end
    end

    assign head_next  = head_reg + PTR_W'(pop_n);
    assign tail_next  = tail_reg + PTR_W'(push_n);
    assign count_next = count_reg + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);

    always_ff @(posedge clk) begin
        if (clear) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            delayslot_reg <= NOT_IN_DELAY_SLOT;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            // The flag follows the head: it only changes when the head moves.
            if (pop_n != 2'd0) begin
                delayslot_reg <= next_inst_in_delayslot_i;
            end
        end
    end

    iq_ram #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (ENTRY_W),
        .RD2_W  (64)
    ) u_ram (
        .clk    (clk),
        .we1    (!clear && (push_n != 2'd0)),
        .waddr1 (tail_reg),
        .wdata1 ({fetch_addr1, fetch_inst1, fetch_pkt1}),
        .we2    (!clear && (push_n == 2'd2)),
        .waddr2 (tail_reg + PTR_W'(1)),
        .wdata2 ({fetch_addr2, fetch_inst2, fetch_pkt2}),
        .raddr1 (head_reg),
        .rdata1 (rd_head),
        .raddr2 (head_reg + PTR_W'(1)),
        .rdata2 (rd_second)
    );

    always_comb begin
        issue_en1     = (count_reg != '0);
        inst_addr_o1  = '0;
        inst_o1       = '0;
        predict_pkt_o = '0;
        inst_addr_o2  = '0;
        inst_o2       = '0;
        if (count_reg != '0) begin
            inst_addr_o1  = rd_head[ENTRY_W-1 -: 32];
            inst_o1       = rd_head[ENTRY_W-33 -: 32];
            predict_pkt_o = rd_head[PKT_W-1:0];
        end
        if (count_reg >= (PTR_W+1)'(2)) begin
            inst_addr_o2 = rd_second[63:32];
            inst_o2      = rd_second[31:0];
        end
    end

    assign is_in_delayslot_o = delayslot_reg;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill/drain, full boundary, wrap, delay slot, flush and reset.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int PKT_W = BPB_PACKET_WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             fetch_valid1;
    logic             fetch_valid2;
    logic [31:0]      fetch_addr1;
    logic [31:0]      fetch_addr2;
    logic [31:0]      fetch_inst1;
    logic [31:0]      fetch_inst2;
    logic [PKT_W-1:0] fetch_pkt1;
    logic [PKT_W-1:0] fetch_pkt2;
    logic             queue_full;
    logic             issue_i;
    logic             issue_mode_i;
    logic             next_inst_in_delayslot_i;
    logic             issue_en1;
    logic [31:0]      inst_addr_o1;
    logic [31:0]      inst_addr_o2;
    logic [31:0]      inst_o1;
    logic [31:0]      inst_o2;
    logic [PKT_W-1:0] predict_pkt_o;
    logic             is_in_delayslot_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    inst_queue dut (
        .clk                      (clk),
        .rst                      (rst),
        .flush                    (flush),
        .fetch_valid1             (fetch_valid1),
        .fetch_valid2             (fetch_valid2),
        .fetch_addr1              (fetch_addr1),
        .fetch_addr2              (fetch_addr2),
        .fetch_inst1              (fetch_inst1),
        .fetch_inst2              (fetch_inst2),
        .fetch_pkt1               (fetch_pkt1),
        .fetch_pkt2               (fetch_pkt2),
        .queue_full               (queue_full),
        .issue_i                  (issue_i),
        .issue_mode_i             (issue_mode_i),
        .next_inst_in_delayslot_i (next_inst_in_delayslot_i),
        .issue_en1                (issue_en1),
        .inst_addr_o1             (inst_addr_o1),
        .inst_addr_o2             (inst_addr_o2),
        .inst_o1                  (inst_o1),
        .inst_o2                  (inst_o2),
        .predict_pkt_o            (predict_pkt_o),
        .is_in_delayslot_o        (is_in_delayslot_o)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [PKT_W-1:0] pkt_of(input logic [31:0] a);
        return {3'b101, a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_fetch(input logic v1, input logic v2, input logic [31:0] a1, input logic [31:0] a2);
        fetch_valid1 = v1;
        fetch_valid2 = v2;
        fetch_addr1  = a1;
        fetch_addr2  = a2;
        fetch_inst1  = inst_of(a1);
        fetch_inst2  = inst_of(a2);
        fetch_pkt1   = pkt_of(a1);
        fetch_pkt2   = pkt_of(a2);
    endtask

    task automatic set_issue(input logic en, input logic mode, input logic nid);
        issue_i                  = en;
        issue_mode_i             = mode;
        next_inst_in_delayslot_i = nid;
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step(input string what);
        @(posedge clk);
        #1;
        $display("[%0t] %s: en1=%0b a1=%h a2=%h full=%0b ds=%0b", $time, what,
                 issue_en1, inst_addr_o1, inst_addr_o2, queue_full, is_in_delayslot_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        rst   = 1'b1;
        flush = 1'b0;
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        step("reset");
        rst = 1'b0;
        check_eq("rst_en1",  64'(issue_en1), 64'd0);
        check_eq("rst_addr1", 64'(inst_addr_o1), 64'd0);
        check_eq("rst_inst1", 64'(inst_o1), 64'd0);
        check_eq("rst_pkt",  64'(predict_pkt_o), 64'd0);
        check_eq("rst_full", 64'(queue_full), 64'd0);
        check_eq("rst_ds",   64'(is_in_delayslot_o), 64'd0);

        // 1: dual push then dual issue
        set_fetch(1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0004);
        step("push A,B");
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t1_en1",   64'(issue_en1), 64'd1);
        check_eq("t1_addr1", 64'(inst_addr_o1), 64'hBFC0_0000);
        check_eq("t1_addr2", 64'(inst_addr_o2), 64'hBFC0_0004);
        check_eq("t1_inst1", 64'(inst_o1), 64'(inst_of(32'hBFC0_0000)));
        check_eq("t1_inst2", 64'(inst_o2), 64'(inst_of(32'hBFC0_0004)));
        check_eq("t1_pkt",   64'(predict_pkt_o), 64'(pkt_of(32'hBFC0_0000)));
        set_issue(1'b1, DUAL_ISSUE, 1'b0);
        step("issue dual");
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t1_empty", 64'(issue_en1), 64'd0);

        // 2: single entry, dual issue pops just one
        set_fetch(1'b1, 1'b0, 32'hBFC0_0008, 32'hFFFF_FFFF);
        step("push C");
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t2_addr1", 64'(inst_addr_o1), 64'hBFC0_0008);
        check_eq("t2_inst2", 64'(inst_o2), 64'd0);
        check_eq("t2_addr2", 64'(inst_addr_o2), 64'd0);
        set_issue(1'b1, DUAL_ISSUE, 1'b0);
        step("issue dual on 1");
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t2_empty", 64'(issue_en1), 64'd0);
        check_eq("t2_full",  64'(queue_full), 64'd0);

        // 3: full boundary
        base = 32'h0000_1000;
        for (int k = 0; k < 7; k++) begin
            set_fetch(1'b1, 1'b1, base + 32'(8*k), base + 32'(8*k + 4));
            step("fill pair");
        end
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t3_full14", 64'(queue_full), 64'd0);
        set_fetch(1'b1, 1'b0, base + 32'd56, 32'h0);
        step("push 15th");
        check_eq("t3_full15", 64'(queue_full), 64'd1);
        set_fetch(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0004);
        step("push while full");
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t3_still_full", 64'(queue_full), 64'd1);
        set_issue(1'b1, SINGLE_ISSUE, 1'b0);
        step("issue single");
        check_eq("t3_full_after_pop", 64'(queue_full), 64'd0);
        for (int k = 0; k < 7; k++) begin
            set_issue(1'b1, DUAL_ISSUE, 1'b0);
            check_eq("t3_drain_a1", 64'(inst_addr_o1), 64'(base + 32'(4 + 8*k)));
            check_eq("t3_drain_a2", 64'(inst_addr_o2), 64'(base + 32'(8 + 8*k)));
            step("drain dual");
        end
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t3_empty", 64'(issue_en1), 64'd0);

        // 4: streaming push-2/pop-2 across pointer wrap
        base = 32'h2000_0000;
        set_fetch(1'b1, 1'b1, base, base + 32'd4);
        step("prefill");
        for (int k = 0; k < 40; k++) begin
            set_fetch(1'b1, 1'b1, base + 32'(8*k + 8), base + 32'(8*k + 12));
            set_issue(1'b1, DUAL_ISSUE, 1'b0);
            check_eq("t4_a1", 64'(inst_addr_o1), 64'(base + 32'(8*k)));
            check_eq("t4_a2", 64'(inst_addr_o2), 64'(base + 32'(8*k + 4)));
            step("stream");
        end
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t4_tail_a1", 64'(inst_addr_o1), 64'(base + 32'd320));
        check_eq("t4_tail_pkt", 64'(predict_pkt_o), 64'(pkt_of(base + 32'd320)));
        set_issue(1'b1, DUAL_ISSUE, 1'b0);
        step("drain stream");
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t4_empty", 64'(issue_en1), 64'd0);

        // 5: delay-slot flag held while decode stalls
        set_fetch(1'b1, 1'b1, 32'h0000_B000, 32'h0000_B004);
        step("push branch,slot");
        set_fetch(1'b1, 1'b1, 32'h0000_B008, 32'h0000_B00C);
        step("push x,y");
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t5_ds_pre", 64'(is_in_delayslot_o), 64'd0);
        set_issue(1'b1, SINGLE_ISSUE, 1'b1);
        step("issue branch");
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t5_ds_set", 64'(is_in_delayslot_o), 64'd1);
        check_eq("t5_slot_head", 64'(inst_addr_o1), 64'h0000_B004);
        for (int k = 0; k < 3; k++) begin
            step("hold");
            check_eq("t5_ds_hold", 64'(is_in_delayslot_o), 64'd1);
        end
        set_issue(1'b1, SINGLE_ISSUE, 1'b0);
        step("issue slot");
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t5_ds_clr", 64'(is_in_delayslot_o), 64'd0);
        check_eq("t5_head", 64'(inst_addr_o1), 64'h0000_B008);

        // 6: flush beats same-cycle push and pop
        set_fetch(1'b1, 1'b1, 32'h0000_C000, 32'h0000_C004);
        step("push");
        set_fetch(1'b1, 1'b1, 32'h0000_C008, 32'h0000_C00C);
        step("push");
        check_eq("t6_en1_6", 64'(issue_en1), 64'd1);
        set_fetch(1'b1, 1'b1, 32'h0000_E000, 32'h0000_E004);
        set_issue(1'b1, DUAL_ISSUE, 1'b1);
        flush = 1'b1;
        step("flush");
        flush = 1'b0;
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        set_issue(1'b0, SINGLE_ISSUE, 1'b0);
        check_eq("t6_en1",   64'(issue_en1), 64'd0);
        check_eq("t6_ds",    64'(is_in_delayslot_o), 64'd0);
        check_eq("t6_addr1", 64'(inst_addr_o1), 64'd0);
        check_eq("t6_full",  64'(queue_full), 64'd0);
        set_fetch(1'b1, 1'b0, 32'h0000_D000, 32'h0);
        step("push D");
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t6_d_en1",  64'(issue_en1), 64'd1);
        check_eq("t6_d_addr", 64'(inst_addr_o1), 64'h0000_D000);
        check_eq("t6_d_inst", 64'(inst_o1), 64'(inst_of(32'h0000_D000)));
        check_eq("t6_d_a2",   64'(inst_addr_o2), 64'd0);

        // Reset mid-operation discards everything
        set_fetch(1'b1, 1'b1, 32'h0000_F000, 32'h0000_F004);
        rst = 1'b1;
        step("reset mid");
        rst = 1'b0;
        set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("rst2_en1",  64'(issue_en1), 64'd0);
        check_eq("rst2_inst", 64'(inst_o1), 64'd0);
        step("idle");
        check_eq("rst2_idle", 64'(issue_en1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction buffer between fetch (IF/icache) and the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle with their branch-prediction packet.
- Presents the two oldest entries to decode and pops 1 or 2 entries according to decode's issue decision.
- Tracks the delay-slot flag for the next head instruction and empties on pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4
- PTR_W, 4, log2(DEPTH)
- PKT_W, 35, branch-prediction packet width (`BPBPacketWidth)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- flush  in  1  pipeline flush from ctrl (exception/mispredict)
- fetch_valid1  in  1  fetch slot 1 carries an instruction
- fetch_valid2  in  1  fetch slot 2 carries an instruction; meaningful only with fetch_valid1
- fetch_addr1 / fetch_addr2  in  32  instruction addresses
- fetch_inst1 / fetch_inst2  in  32  instruction words
- fetch_pkt1 / fetch_pkt2  in  PKT_W  prediction packet per slot
- queue_full  out  1  fewer than 2 free entries; fetch must hold its slots
- issue_i  in  1  decode issued this cycle (decode issue_o)
- issue_mode_i  in  1  `DualIssue / `SingleIssue from decode
- next_inst_in_delayslot_i  in  1  from decode
- issue_en1  out  1  head entry valid (to decode issue_en1)
- inst_addr_o1 / inst_addr_o2  out  32  head / head+1 address
- inst_o1 / inst_o2  out  32  head / head+1 instruction word
- predict_pkt_o  out  PKT_W  head entry packet
- is_in_delayslot_o  out  1  head instruction is a delay slot

Behaviour:
- Storage: DEPTH entries of {addr, inst, pkt}; head and tail pointers PTR_W bits wrapping modulo DEPTH; count PTR_W+1 bits, range 0..DEPTH.
- Reset (synchronous):
  - head = tail = count = 0; is_in_delayslot_o = 0.
  - Outputs therefore read as empty: issue_en1 = 0; inst/addr/pkt outputs = 0; queue_full = 0.
- Push:
  - push_n = 0 when queue_full or !fetch_valid1; otherwise 1 + fetch_valid2.
  - Slot 1 is written at tail, slot 2 at tail+1; tail advances by push_n.
  - fetch_valid2 without fetch_valid1 pushes nothing.
- Read outputs are combinational from storage. A pushed entry is visible on the outputs the cycle after the push (1-cycle latency); there is no bypass.
  - issue_en1 = (count >= 1).
  - When count == 1, inst_o2 = 0 (NOP) and inst_addr_o2 = 0.
  - When count == 0, all data outputs = 0.
- Pop:
  - pop_n = 0 if !issue_i or count == 0.
  - pop_n = 2 if issue_mode_i == `DualIssue and count >= 2.
  - pop_n = 1 otherwise. A dual issue with a single valid entry pops 1, because the NOP slot is not stored.
  - head advances by pop_n.
- Simultaneous push and pop are allowed in the same cycle: count_next = count + push_n - pop_n.
- queue_full is combinational: (DEPTH - count) < 2. It is evaluated on the current count and does not account for the same-cycle pop.
- Delay slot:
  - On a cycle with pop_n != 0, is_in_delayslot_o <= next_inst_in_delayslot_i.
  - Otherwise it holds, so the flag stays attached to the waiting head instruction.
- Flush has highest priority over push and pop:
  - head = tail = count = 0; is_in_delayslot_o = 0.
  - Same-cycle pushes are discarded.
  - ctrl asserts flush only after any pending delay slot has issued.
- Reset asserted mid-operation behaves exactly like flush and discards all entries.
- Wrap: tail+1 and head+1 wrap modulo DEPTH, including when the pointer is at DEPTH-1.
- Overflow and underflow cannot occur by construction. The verifier asserts count never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared defines.v holds:
  - `BPBPacketWidth, `DualIssue/`SingleIssue, `InDelaySlot/`NotInDelaySlot, `RstEnable.
  - New constant `InstQueueDepth (16).
- One sub-module: iq_ram, a DEPTH x (64+PKT_W) register array with two write ports and two asynchronous read ports. The pointer/count control stays in inst_queue.

Test Plan:
1. Reset, then push A@0xBFC00000 + B@0xBFC00004 in one cycle -> next cycle:
   - issue_en1 = 1, inst_addr_o1 = 0xBFC00000, inst_addr_o2 = 0xBFC00004.
   - Issue dual -> count = 0, issue_en1 = 0.
2. Push a single instruction C (fetch_valid2 = 0), then issue_i = 1 with issue_mode_i = Dual:
   - While C waits: inst_o2 = 0, inst_addr_o2 = 0.
   - After issue: exactly one entry popped, count = 0.
3. Fill to 14 entries:
   - queue_full = 0.
   - Push 1 -> count = 15, queue_full = 1; fetch valid asserted that cycle is not accepted.
   - Single issue -> count = 14, queue_full = 0.
4. Run 40 push-2/pop-2 cycles with sequential addresses so head and tail wrap past entry 15 -> addresses emerge in order, no gaps.
5. Issue a branch single with next_inst_in_delayslot_i = 1, then hold issue_i = 0 for 3 cycles -> is_in_delayslot_o = 1 throughout the hold; clears to 0 after the slot issues with next_inst_in_delayslot_i = 0.
6. Queue holding 6 entries, assert flush together with push-2 and issue_i = 1 -> next cycle count = 0, issue_en1 = 0, is_in_delayslot_o = 0; a later push appears at the head.
